// File: rtl/secuenciador_fases_pkg.sv
// Shared definitions for the fill/agitate/drain phase sequencer.
// Build option SECUENCIADOR_FALSA_FILTRO_EN: require falsa high on two consecutive edges to abort.
package secuenciador_fases_pkg;

  typedef enum logic [2:0] {
    REPOSO  = 3'd0,
    LLENADO = 3'd1,
    LAVADO  = 3'd2,
    VACIADO = 3'd3,
    FIN     = 3'd4
  } estado_t;

  localparam int T_LLENADO_DEF = 4;
  localparam int T_LAVADO_DEF  = 8;
  localparam int T_VACIADO_DEF = 3;
  localparam int CW_DEF        = 4;

endpackage

// File: rtl/secuenciador_fases_temporizador_fase.sv
// Loadable phase down-counter; fin flags a zero count so a phase loaded with T-1 lasts T cycles.
module temporizador_fase #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          carga,
  input  logic [CW-1:0] valor,
  output logic          fin
);

  logic [CW-1:0] cuenta;

  // Holds at zero once expired so idle states never wrap the count.
  always_ff @(posedge clk) begin
    if (reset)
      cuenta <= '0;
    else if (carga)
      cuenta <= valor;
    else if (cuenta != '0)
      cuenta <= cuenta - 1'b1;
  end

  assign fin = (cuenta == '0);

endmodule

// File: rtl/secuenciador_fases.sv
// Timed fill/agitate/drain sequencer: FSM, inicio edge detector, sticky abort flag E.
// Build option SECUENCIADOR_FALSA_FILTRO_EN adds a two-edge confirmation filter on falsa.
module secuenciador_fases
  import secuenciador_fases_pkg::*;
#(
  parameter int T_LLENADO = T_LLENADO_DEF,
  parameter int T_LAVADO  = T_LAVADO_DEF,
  parameter int T_VACIADO = T_VACIADO_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic       falsa,
  output logic       L,
  output logic       A,
  output logic       Y,
  output logic       B,
  output logic       F,
  output logic       E,
  output logic [2:0] fase
);

  localparam logic [CW-1:0] CARGA_LL = CW'(T_LLENADO - 1);
  localparam logic [CW-1:0] CARGA_LA = CW'(T_LAVADO - 1);
  localparam logic [CW-1:0] CARGA_VA = CW'(T_VACIADO - 1);

  estado_t       estado_q, estado_d;
  logic          inicio_q, e_q;
  logic          arranque, abortar, abort_cond;
  logic          carga, fin_fase;
  logic [CW-1:0] valor;

`ifdef SECUENCIADOR_FALSA_FILTRO_EN
  logic falsa_q;

  // A phase change restarts confirmation so a pulse cannot straddle two phases.
  always_ff @(posedge clk) begin
    if (reset || (estado_d != estado_q))
      falsa_q <= 1'b0;
    else
      falsa_q <= falsa;
  end

  assign abort_cond = falsa & falsa_q;
`else
  assign abort_cond = falsa;
`endif

  temporizador_fase #(.CW(CW)) u_temporizador (
    .clk   (clk),
    .reset (reset),
    .carga (carga),
    .valor (valor),
    .fin   (fin_fase)
  );

  // Abort outranks both a start request and a normal phase expiry.
  always_comb begin
    estado_d = estado_q;
    carga    = 1'b0;
    valor    = '0;
    arranque = 1'b0;
    abortar  = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (inicio && !inicio_q && !abort_cond) begin
          arranque = 1'b1;
          estado_d = LLENADO;
          carga    = 1'b1;
          valor    = CARGA_LL;
        end
      end
      LLENADO: begin
        if (abort_cond) begin
          abortar  = 1'b1;
          estado_d = VACIADO;
          carga    = 1'b1;
          valor    = CARGA_VA;
        end else if (fin_fase) begin
          estado_d = LAVADO;
          carga    = 1'b1;
          valor    = CARGA_LA;
        end
      end
      LAVADO: begin
        if (abort_cond) begin
          abortar  = 1'b1;
          estado_d = VACIADO;
          carga    = 1'b1;
          valor    = CARGA_VA;
        end else if (fin_fase) begin
          estado_d = VACIADO;
          carga    = 1'b1;
          valor    = CARGA_VA;
        end
      end
      VACIADO: if (fin_fase) estado_d = FIN;
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  // inicio_q resets high so an inicio already asserted at reset release is not a start.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= REPOSO;
      inicio_q <= 1'b1;
      e_q      <= 1'b0;
      L        <= 1'b0;
      A        <= 1'b0;
      Y        <= 1'b0;
      B        <= 1'b0;
      F        <= 1'b0;
    end else begin
      estado_q <= estado_d;
      inicio_q <= inicio;
      if (arranque)
        e_q <= 1'b0;
      else if (abortar)
        e_q <= 1'b1;
      L <= (estado_d == LLENADO);
      A <= (estado_d == LAVADO);
      Y <= (estado_d == VACIADO);
      B <= (estado_d != REPOSO);
      F <= (estado_d == FIN);
    end
  end

  assign fase = estado_q;
  assign E    = e_q;

endmodule
